wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Owns the register-file write port (rd, wr_data, wr_en) and merges writebacks from two sources.
- Source 1 is the in-order pipeline writeback, single-cycle and highest priority.
- Source 2 is the long-latency unit (divider/load-miss) over a valid/ready handshake; its results are buffered in a small FIFO.
- Exports a pending-destination mask to the hazard unit and a stall request when buffered results starve.

Parameters:
DEPTH, 4, long-latency result FIFO entries (power of two, >=2)
STARVE_MAX, 8, consecutive cycles a non-empty FIFO may be blocked before wb_stall_req asserts

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous active-high
pipe_wb_en  input  1  pipeline writeback valid this cycle
pipe_rd  input  5  pipeline destination register
pipe_wr_data  input  32  pipeline result
lu_valid  input  1  long-latency result valid
lu_ready  output  1  FIFO can accept (= !full)
lu_rd  input  5  long-latency destination register
lu_data  input  32  long-latency result
rd  output  5  register-file write address (registered)
wr_data  output  32  register-file write data (registered)
wr_en  output  1  register-file write enable (registered)
pending_mask  output  32  bit i set when any FIFO entry targets xi; bit 0 always 0
fifo_count  output  $clog2(DEPTH+1)  current FIFO occupancy
wb_stall_req  output  1  request pipeline to stop issuing writebacks

Behaviour:
- One clock, clk; synchronous active-high reset, rst. All state changes occur on the rising edge.
- Reset values:
  - rd=0, wr_data=0, wr_en=0.
  - FIFO empty, so fifo_count=0, pending_mask=0 and lu_ready=1.
  - Starvation counter=0, wb_stall_req=0.
- Reset mid-operation discards all FIFO contents and any in-flight output.
- Pipeline write latency: pipe_wb_en && pipe_rd!=0 sampled at edge N → rd/wr_data/wr_en driven for the cycle after edge N.
- Slot selection, evaluated each cycle in priority order:
  - (a) Pipeline write to a nonzero rd takes the slot.
  - (b) Otherwise, if the FIFO is non-empty, pop the head and drive it.
  - (c) Otherwise wr_en=0 next cycle; rd/wr_data hold their last values.
- A pipeline write to x0 is dropped and the slot is free for FIFO use.
- Handshake:
  - Accept happens when lu_valid && lu_ready at the edge.
  - lu_ready depends on full only. There is no same-cycle pass-through when full, even if a pop occurs that cycle.
  - An accepted result with lu_rd=0 is consumed and discarded, never enqueued.
  - Simultaneous push and pop while not full: both occur and fifo_count is unchanged.
- Ordering and masks:
  - The FIFO is strictly in order. Duplicate rd entries drain oldest first, so the youngest value wins.
  - pending_mask is recomputed from registered FIFO contents and reflects the post-edge state.
  - The hazard unit uses pending_mask to stall WAW/RAW against buffered results; this block does not check pipe_rd against the FIFO.
- Pointers:
  - Read/write pointers are $clog2(DEPTH)+1 bits wide, so wrap-around is natural modulo 2·DEPTH.
  - full = MSBs differ and LSBs equal; empty = pointers equal.
- Starvation:
  - The counter increments each cycle where FIFO is non-empty and the slot went to the pipeline.
  - It clears on any FIFO pop or when the FIFO is empty.
  - When counter==STARVE_MAX, wb_stall_req=1 (registered). It stays high until the FIFO becomes empty.
  - The counter saturates at STARVE_MAX.
  - While wb_stall_req is high, a pipe_wb_en arriving anyway is still served first; no write is ever lost.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: when the FIFO is empty, the slot is free, and an accepted lu result has nonzero rd, it goes straight to the output registers without enqueuing. Latency is 1 cycle and pending_mask is never set for it.
- Undefined: every lu result is enqueued first. Minimum latency is 2 cycles (push edge, pop edge).

Decomposition:
- Package wb_pkg holds:
  - XLEN=32, REG_AW=5, ZERO_REG=5'd0.
  - Typedef wb_entry_t = {rd[4:0], data[31:0]}.
- Sub-module wb_fifo (parameter DEPTH) implements storage, pointers, full/empty/count and exposes per-entry rd for mask generation.
- Top level contains the slot arbiter, output registers and starvation counter.

Test Plan:
1. Pipe write: pipe_wb_en=1, pipe_rd=5, data=0x12345678 at edge N → next cycle rd=5, wr_data=0x12345678, wr_en=1. Then pipe idle → wr_en=0.
2. Buffered drain:
   - lu push rd=7, data=0xDEADBEEF while the pipe writes x1..x3 for 3 cycles → pending_mask=0x80 and fifo_count=1.
   - Write to x7 appears the cycle after the pipe goes idle; mask then returns to 0.
3. Full FIFO: 4 pushes with the pipe continuously busy → lu_ready=0 and fifo_count=4. A 5th lu_valid is held until a pop; order is preserved across wrap after 6 push/pop pairs.
4. x0 handling:
   - pipe_wb_en=1, pipe_rd=0 with FIFO head rd=9 → head is written next cycle.
   - lu push with lu_rd=0 → fifo_count unchanged, no write.
5. Starvation: FIFO holds 1 entry and the pipe writes nonzero rd every cycle → wb_stall_req rises after 8 blocked cycles. When the pipe drops, the entry is written and wb_stall_req falls once the FIFO is empty.
6. Reset mid-op: 3 entries queued with wr_en=1, assert rst for one cycle → wr_en=0, fifo_count=0, pending_mask=0, lu_ready=1 and wb_stall_req=0 next cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Contents: datapath/register-address widths, the x0 encoding, and the
// buffered writeback entry type used by the long-latency FIFO.
package wb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order result FIFO for the long-latency writeback source.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   push, push_rd/data    enqueue request (ignored while full)
//   pop                   dequeue request (ignored while empty)
//   head_rd/head_data     oldest entry
//   full, empty, count    occupancy status
//   entry_rd, entry_live  per-slot destination register and occupancy flag,
//                         flattened, for pending-mask generation
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [REG_AW-1:0]             push_rd,
  input  logic [XLEN-1:0]               push_data,
  input  logic                          pop,
  output logic [REG_AW-1:0]             head_rd,
  output logic [XLEN-1:0]               head_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic [DEPTH*REG_AW-1:0]       entry_rd,
  output logic [DEPTH-1:0]              entry_live
);

  localparam int unsigned AW = $clog2(DEPTH);

  wb_entry_t      mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_rd   = mem[rd_ptr[AW-1:0]].rd;
  assign head_data = mem[rd_ptr[AW-1:0]].data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= '{rd: push_rd, data: push_data};
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // A slot is live when its distance from the read index is below the
  // occupancy; storage itself is never cleared, so stale slots are masked here.
  always_comb begin
    logic [AW-1:0] offs;
    entry_rd   = '0;
    entry_live = '0;
    offs       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_rd[i*REG_AW +: REG_AW] = mem[i].rd;
      offs          = AW'(i) - rd_ptr[AW-1:0];
      entry_live[i] = ({1'b0, offs} < count);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter. Merges single-cycle pipeline writebacks
// (highest priority) with buffered long-latency results, exports a
// pending-destination mask and a starvation stall request.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   pipe_wb_en/pipe_rd/pipe_wr_data  pipeline writeback
//   lu_valid/lu_ready/lu_rd/lu_data  long-latency result handshake
//   rd/wr_data/wr_en                 registered register-file write port
//   pending_mask                     registers targeted by buffered results
//   fifo_count                       buffered result count
//   wb_stall_req                     request to stop pipeline writebacks
// Optional feature: define WB_BYPASS_EN to let a result arriving at an
// empty FIFO with a free slot go straight to the write port.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pipe_wb_en,
  input  logic [4:0]                    pipe_rd,
  input  logic [31:0]                   pipe_wr_data,
  input  logic                          lu_valid,
  output logic                          lu_ready,
  input  logic [4:0]                    lu_rd,
  input  logic [31:0]                   lu_data,
  output logic [4:0]                    rd,
  output logic [31:0]                   wr_data,
  output logic                          wr_en,
  output logic [31:0]                   pending_mask,
  output logic [$clog2(DEPTH+1)-1:0]    fifo_count,
  output logic                          wb_stall_req
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = $clog2(STARVE_MAX+1);

  logic                     fifo_full;
  logic                     fifo_empty;
  logic [REG_AW-1:0]        head_rd;
  logic [XLEN-1:0]          head_data;
  logic [DEPTH*REG_AW-1:0]  entry_rd;
  logic [DEPTH-1:0]         entry_live;

  logic                     accept;
  logic                     pipe_take;
  logic                     pop;
  logic                     push;
  logic                     bypass;
  logic [CW-1:0]            count_next;
  logic [SW-1:0]            starve_cnt;
  logic [SW-1:0]            starve_next;
  logic                     stall_next;

  assign lu_ready  = !fifo_full;
  assign accept    = lu_valid && lu_ready;
  assign pipe_take = pipe_wb_en && (pipe_rd != ZERO_REG);
  assign pop       = !pipe_take && !fifo_empty;

`ifdef WB_BYPASS_EN
  assign bypass = !pipe_take && fifo_empty && accept && (lu_rd != ZERO_REG);
`else
  assign bypass = 1'b0;
`endif

  // Results for x0 are accepted but never stored.
  assign push = accept && (lu_rd != ZERO_REG) && !bypass;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_rd    (lu_rd),
    .push_data  (lu_data),
    .pop        (pop),
    .head_rd    (head_rd),
    .head_data  (head_data),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .entry_rd   (entry_rd),
    .entry_live (entry_live)
  );

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_live[i]) begin
        pending_mask[entry_rd[i*REG_AW +: REG_AW]] = 1'b1;
      end
    end
    pending_mask[0] = 1'b0;
  end

  // Stall release tracks the post-edge occupancy so it drops on the same
  // edge that drains the last buffered result.
  always_comb begin
    count_next = fifo_count + CW'(push) - CW'(pop);
    if (fifo_empty || pop) begin
      starve_next = '0;
    end else if (pipe_take && (starve_cnt != SW'(STARVE_MAX))) begin
      starve_next = starve_cnt + 1'b1;
    end else begin
      starve_next = starve_cnt;
    end
    stall_next = (count_next != '0) &&
                 (wb_stall_req || (starve_next == SW'(STARVE_MAX)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt   <= '0;
      wb_stall_req <= 1'b0;
    end else begin
      starve_cnt   <= starve_next;
      wb_stall_req <= stall_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd      <= '0;
      wr_data <= '0;
      wr_en   <= 1'b0;
    end else if (pipe_take) begin
      rd      <= pipe_rd;
      wr_data <= pipe_wr_data;
      wr_en   <= 1'b1;
    end else if (pop) begin
      rd      <= head_rd;
      wr_data <= head_data;
      wr_en   <= 1'b1;
    end else if (bypass) begin
      rd      <= lu_rd;
      wr_data <= lu_data;
      wr_en   <= 1'b1;
    end else begin
      wr_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (default build, DEPTH=4,
// STARVE_MAX=8).
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_en;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wr_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic [4:0]  rd;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [31:0] pending_mask;
  logic [2:0]  fifo_count;
  logic        wb_stall_req;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .DEPTH      (4),
    .STARVE_MAX (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_wb_en   (pipe_wb_en),
    .pipe_rd      (pipe_rd),
    .pipe_wr_data (pipe_wr_data),
    .lu_valid     (lu_valid),
    .lu_ready     (lu_ready),
    .lu_rd        (lu_rd),
    .lu_data      (lu_data),
    .rd           (rd),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .pending_mask (pending_mask),
    .fifo_count   (fifo_count),
    .wb_stall_req (wb_stall_req)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1ns after the active edge; inputs change there too.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    pipe_wb_en   = 1'b0;
    pipe_rd      = 5'd0;
    pipe_wr_data = 32'd0;
    lu_valid     = 1'b0;
    lu_rd        = 5'd0;
    lu_data      = 32'd0;
  endtask

  task automatic pipe(input logic [4:0] r, input logic [31:0] d);
    pipe_wb_en   = 1'b1;
    pipe_rd      = r;
    pipe_wr_data = d;
  endtask

  task automatic lu(input logic [4:0] r, input logic [31:0] d);
    lu_valid = 1'b1;
    lu_rd    = r;
    lu_data  = d;
  endtask

  task automatic check_wr(input string tag, input logic [4:0] r, input logic [31:0] d);
    check({tag, " wr_en"},   32'(wr_en),   32'd1);
    check({tag, " rd"},      32'(rd),      32'(r));
    check({tag, " wr_data"}, wr_data,      d);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    check("rst wr_en",   32'(wr_en),        32'd0);
    check("rst rd",      32'(rd),           32'd0);
    check("rst wr_data", wr_data,           32'd0);
    check("rst count",   32'(fifo_count),   32'd0);
    check("rst mask",    pending_mask,      32'd0);
    check("rst ready",   32'(lu_ready),     32'd1);
    check("rst stall",   32'(wb_stall_req), 32'd0);
    rst = 1'b0;

    // 1. pipeline write, one-cycle latency
    pipe(5'd5, 32'h1234_5678);
    tick();
    check_wr("t1", 5'd5, 32'h1234_5678);
    idle();
    tick();
    check("t1 idle wr_en", 32'(wr_en), 32'd0);
    check("t1 hold rd",    32'(rd),    32'd5);
    check("t1 hold data",  wr_data,    32'h1234_5678);

    // 2. buffered drain behind three pipeline writes
    pipe(5'd1, 32'h11);
    lu(5'd7, 32'hDEAD_BEEF);
    tick();
    lu_valid = 1'b0;
    check_wr("t2 c1", 5'd1, 32'h11);
    check("t2 c1 count", 32'(fifo_count), 32'd1);
    check("t2 c1 mask",  pending_mask,    32'h80);
    pipe(5'd2, 32'h22);
    tick();
    check_wr("t2 c2", 5'd2, 32'h22);
    pipe(5'd3, 32'h33);
    tick();
    check_wr("t2 c3", 5'd3, 32'h33);
    check("t2 c3 count", 32'(fifo_count), 32'd1);
    check("t2 c3 mask",  pending_mask,    32'h80);
    idle();
    tick();
    check_wr("t2 drain", 5'd7, 32'hDEAD_BEEF);
    check("t2 drain count", 32'(fifo_count), 32'd0);
    check("t2 drain mask",  pending_mask,    32'd0);
    tick();
    check("t2 after wr_en", 32'(wr_en), 32'd0);

    // 2b. lu result into idle port takes two edges without bypass
    lu(5'd4, 32'h44);
    tick();
    idle();
    check("t2b push wr_en", 32'(wr_en),      32'd0);
    check("t2b push count", 32'(fifo_count), 32'd1);
    check("t2b push mask",  pending_mask,    32'h10);
    tick();
    check_wr("t2b pop", 5'd4, 32'h44);

    // 3. fill the FIFO while the pipeline owns the slot
    for (int i = 0; i < 4; i++) begin
      pipe(5'd10, 32'h100 + 32'(i));
      lu(5'(11 + i), 32'hA0 + 32'(i));
      tick();
    end
    check("t3 full count", 32'(fifo_count), 32'd4);
    check("t3 full ready", 32'(lu_ready),   32'd0);
    check("t3 full mask",  pending_mask,    32'h0000_7800);
    lu(5'd15, 32'hA4);
    tick();
    check("t3 held count", 32'(fifo_count), 32'd4);
    check("t3 held wr rd", 32'(rd),         32'd10);
    pipe_wb_en = 1'b0;
    tick();
    check_wr("t3 pop0", 5'd11, 32'hA0);
    check("t3 pop0 count", 32'(fifo_count), 32'd3);
    check("t3 pop0 ready", 32'(lu_ready),   32'd1);
    tick();
    lu_valid = 1'b0;
    check_wr("t3 pop1", 5'd12, 32'hA1);
    check("t3 pop1 count", 32'(fifo_count), 32'd3);
    check("t3 pop1 mask",  pending_mask,    32'h0000_E000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_wr($sformatf("t3 drain%0d", i), 5'(13 + i), 32'hA2 + 32'(i));
      check($sformatf("t3 drain%0d count", i), 32'(fifo_count), 32'(2 - i));
    end
    for (int k = 0; k < 6; k++) begin
      lu(5'(16 + k), 32'hB0 + 32'(k));
      tick();
      if (k == 0) begin
        check("t3 wrap first wr_en", 32'(wr_en), 32'd0);
      end else begin
        check_wr($sformatf("t3 wrap%0d", k), 5'(16 + k - 1), 32'hB0 + 32'(k - 1));
      end
      check($sformatf("t3 wrap%0d count", k), 32'(fifo_count), 32'd1);
    end
    idle();
    tick();
    check_wr("t3 wrap last", 5'd21, 32'hB5);
    check("t3 wrap last count", 32'(fifo_count), 32'd0);

    // 4. x0 handling
    pipe(5'd10, 32'h1010);
    lu(5'd9, 32'h99);
    tick();
    lu_valid = 1'b0;
    check("t4 head count", 32'(fifo_count), 32'd1);
    pipe(5'd0, 32'hFFFF_FFFF);
    tick();
    check_wr("t4 x0 pipe", 5'd9, 32'h99);
    check("t4 x0 pipe count", 32'(fifo_count), 32'd0);
    idle();
    lu(5'd0, 32'h55);
    tick();
    lu_valid = 1'b0;
    check("t4 lu x0 count", 32'(fifo_count), 32'd0);
    check("t4 lu x0 wr_en", 32'(wr_en),      32'd0);
    check("t4 lu x0 mask",  pending_mask,    32'd0);
    tick();
    check("t4 lu x0 later wr_en", 32'(wr_en), 32'd0);
    check("t4 lu x0 rd hold",     32'(rd),    32'd9);

    // 5. starvation
    pipe(5'd1, 32'h1);
    lu(5'd20, 32'hC0);
    tick();
    lu_valid = 1'b0;
    check("t5 push stall", 32'(wb_stall_req), 32'd0);
    for (int i = 1; i <= 7; i++) begin
      pipe(5'd1, 32'h1 + 32'(i));
      tick();
      check($sformatf("t5 blocked%0d stall", i), 32'(wb_stall_req), 32'd0);
    end
    pipe(5'd1, 32'h9);
    tick();
    check("t5 blocked8 stall", 32'(wb_stall_req), 32'd1);
    pipe(5'd2, 32'h2222);
    tick();
    check("t5 sat stall", 32'(wb_stall_req), 32'd1);
    check_wr("t5 pipe first", 5'd2, 32'h2222);
    check("t5 sat count", 32'(fifo_count), 32'd1);
    idle();
    tick();
    check_wr("t5 drain", 5'd20, 32'hC0);
    check("t5 drain stall", 32'(wb_stall_req), 32'd0);
    check("t5 drain count", 32'(fifo_count),   32'd0);

    // 6. reset mid-operation
    for (int i = 0; i < 3; i++) begin
      pipe(5'd2, 32'h2);
      lu(5'(21 + i), 32'hD0 + 32'(i));
      tick();
    end
    check("t6 pre count", 32'(fifo_count), 32'd3);
    check("t6 pre wr_en", 32'(wr_en),      32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    check("t6 rst wr_en", 32'(wr_en),        32'd0);
    check("t6 rst count", 32'(fifo_count),   32'd0);
    check("t6 rst mask",  pending_mask,      32'd0);
    check("t6 rst ready", 32'(lu_ready),     32'd1);
    check("t6 rst stall", 32'(wb_stall_req), 32'd0);
    tick();
    check("t6 post wr_en", 32'(wr_en),      32'd0);
    check("t6 post count", 32'(fifo_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
